// File: rtl/instr_prefetch_if.sv
// Fetch-stage bus: instruction-memory req/gnt/rvalid side plus the decode-facing head/redirect side.
// Handshakes: imem issue = imem_req & imem_gnt; decode pop = instr_valid & instr_ready (redirect only counts with a pop).
interface instr_prefetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        redirect;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc, op, funct3, funct7,
    input  instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc, op, funct3, funct7,
    output instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: issues word fetches, buffers responses in a FIFO and
// flushes stale entries and in-flight responses when decode redirects the PC.
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  instr_prefetch_if.master  bus,
  output logic              o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;

  logic [CW:0]   w_inflight;
  logic          w_req;
  logic          w_issue;
  logic          w_rsp;
  logic          w_keep;
  logic          w_valid;
  logic          w_pop;
  logic          w_redirect;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] w_drop_nxt;
  logic [31:0]   w_target;
  logic [31:0]   w_head_instr;
  logic [31:0]   w_head_pc;

  // Buffered plus outstanding never exceeds DEPTH, so a kept response always has a free slot.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req      = reset && (w_inflight < LIMIT);
  assign w_issue    = w_req && bus.imem_gnt;
  assign w_rsp      = reset && bus.imem_rvalid && (r_outstanding != '0);
  assign w_valid    = reset && (r_count != '0);
  assign w_pop      = w_valid && bus.instr_ready;
  assign w_redirect = w_pop && bus.redirect;
  assign w_keep     = w_rsp && (r_drop == '0) && !w_redirect;
  assign w_target   = bus.redirect_target & ~32'h3;

  assign w_outstanding_nxt = r_outstanding + CW'(w_issue) - CW'(w_rsp);

  // On redirect every fetch still in flight after this cycle belongs to the old stream.
  always_comb begin
    w_drop_nxt = r_drop;
    if (w_redirect) begin
      w_drop_nxt = w_outstanding_nxt;
    end else if (w_rsp && (r_drop != '0)) begin
      w_drop_nxt = r_drop - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_redirect && (w_drop_nxt != '0)) w_state_nxt = FLUSH;
      FLUSH:   if (w_drop_nxt == '0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= RUN;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_keep) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_keep) begin
      r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  assign w_head_instr = reset ? r_mem_instr[r_rd_ptr] : 32'h0;
  assign w_head_pc    = reset ? r_mem_pc[r_rd_ptr]    : 32'h0;

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_head_instr;
  assign bus.instr_pc    = w_head_pc;
  assign bus.op          = w_head_instr[6:0];
  assign bus.funct3      = w_head_instr[14:12];
  assign bus.funct7      = w_head_instr[31:25];
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: in-order memory model, expected-PC scoreboard checked on
// every decode pop, plus direct checks of fetch addresses, reset outputs and FSM state.
module tb_instr_prefetch;
  logic clk;
  logic reset;
  logic dbg_state;

  instr_prefetch_if bus();

  instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] addr;
  } pend_t;

  logic [31:0] exp_q[$];
  logic [31:0] iss_log[$];
  pend_t       pend_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned lat = 1;
  int unsigned cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ a[15:0] ^ 16'h3C7B};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory: samples issues between edges, answers in order after lat cycles.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend_q.delete();
      end else if (bus.imem_req && bus.imem_gnt) begin
        pend_q.push_back('{due: cyc + lat, addr: bus.imem_addr});
        iss_log.push_back(bus.imem_addr);
      end
      @(posedge clk);
      #1;
      cyc++;
      bus.imem_rvalid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        bus.imem_rdata  = word_of(pend_q[0].addr);
        bus.imem_rvalid = 1'b1;
        void'(pend_q.pop_front());
      end
    end
  end

  // Scoreboard monitor: every pop must match the next expected PC and its memory word.
  always @(negedge clk) begin
    if (reset && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual_pc=%h expected=none", bus.instr_pc);
      end else begin
        logic [31:0] e_pc;
        logic [31:0] e_w;
        e_pc = exp_q.pop_front();
        e_w  = word_of(e_pc);
        chk("pop_pc", bus.instr_pc, e_pc);
        chk("pop_instr", bus.instr, e_w);
        chk("pop_op", 32'(bus.op), 32'(e_w[6:0]));
        chk("pop_funct3", 32'(bus.funct3), 32'(e_w[14:12]));
        chk("pop_funct7", 32'(bus.funct7), 32'(e_w[31:25]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic g);
    bus.instr_ready     = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    bus.imem_gnt        = g;
    reset = 1'b0;
    repeat (3) step();
    chk("leftover_exp", exp_q.size(), 0);
    exp_q.delete();
    iss_log.delete();
    reset = 1'b1;
  endtask

  // Pops exactly n head entries; redirect (if requested) rides on the last one.
  task automatic consume(input int n, input logic redir, input logic [31:0] tgt);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 200) begin
      bus.instr_ready     = 1'b1;
      bus.redirect        = redir && (got == n - 1);
      bus.redirect_target = tgt;
      @(negedge clk);
      if (bus.instr_valid) got++;
      step();
      guard++;
    end
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    chk("consume_count", got, n);
  endtask

  initial begin
    reset = 1'b0;
    bus.imem_gnt        = 1'b1;
    bus.instr_ready     = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_pc", bus.instr_pc, 0);

    // 1: streaming with 1-cycle memory and decode always ready
    lat = 1;
    do_reset(1'b1);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    chk("t1_req0", bus.imem_req, 1);
    chk("t1_addr0", bus.imem_addr, 32'h0);
    chk("t1_valid0", bus.instr_valid, 0);
    step();
    @(negedge clk);
    chk("t1_addr1", bus.imem_addr, 32'h4);
    chk("t1_valid1", bus.instr_valid, 0);
    step();
    @(negedge clk);
    chk("t1_addr2", bus.imem_addr, 32'h8);
    chk("t1_valid2", bus.instr_valid, 1);
    step();
    consume(7, 1'b0, 32'h0);

    // 2: back-pressure caps issues at DEPTH, then requests resume at 16
    do_reset(1'b1);
    repeat (10) step();
    @(negedge clk);
    chk("t2_issues", iss_log.size(), 4);
    chk("t2_req_idle", bus.imem_req, 0);
    chk("t2_addr_hold", bus.imem_addr, 32'h10);
    step();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    consume(4, 1'b0, 32'h0);
    chk("t2_resume", (iss_log.size() > 4) ? iss_log[4] : 32'hFFFF_FFFF, 32'h10);

    // 3: redirect with two fetches outstanding
    do_reset(1'b1);
    repeat (10) step();
    bus.imem_gnt = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    consume(2, 1'b0, 32'h0);
    lat = 10;
    bus.imem_gnt = 1'b1;
    repeat (2) step();
    bus.imem_gnt = 1'b0;
    chk("t3_outstanding_issues", iss_log.size(), 6);
    exp_q.push_back(32'h8);
    consume(1, 1'b1, 32'h100);
    @(negedge clk);
    chk("t3_state_flush", dbg_state, 1);
    chk("t3_addr", bus.imem_addr, 32'h100);
    step();
    bus.imem_gnt = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    consume(3, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_state_run", dbg_state, 0);
    step();

    // 4: redirect without ready is ignored; unaligned target is word-aligned
    lat = 1;
    do_reset(1'b1);
    repeat (10) step();
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h400;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_noredir_pc", bus.instr_pc, 32'h0);
      chk("t4_noredir_issues", iss_log.size(), 4);
      chk("t4_noredir_state", dbg_state, 0);
      step();
    end
    bus.redirect = 1'b0;
    exp_q.push_back(32'h0);
    consume(1, 1'b1, 32'h0000_0203);
    @(negedge clk);
    chk("t4_req", bus.imem_req, 1);
    chk("t4_addr", bus.imem_addr, 32'h200);
    step();
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    consume(2, 1'b0, 32'h0);

    // 5: grant withheld keeps request stable; 3-cycle memory keeps order
    lat = 3;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_req_hold", bus.imem_req, 1);
      chk("t5_addr_hold", bus.imem_addr, 32'h0);
      chk("t5_no_issue", iss_log.size(), 0);
      step();
    end
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    consume(6, 1'b0, 32'h0);

    // 6: address wrap at the top of memory, then reset mid-stream
    lat = 1;
    do_reset(1'b1);
    repeat (10) step();
    exp_q.push_back(32'h0);
    consume(1, 1'b1, 32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    consume(4, 1'b0, 32'h0);
    chk("t6_wrap_addr", (iss_log.size() > 6) ? iss_log[6] : 32'hDEAD_BEEF, 32'h0);
    repeat (6) step();
    @(negedge clk);
    chk("t6_valid_before", bus.instr_valid, 1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", bus.instr_valid, 0);
    chk("t6_rst_req", bus.imem_req, 0);
    chk("t6_rst_pc", bus.instr_pc, 0);
    step();
    @(negedge clk);
    chk("t6_rst_addr", bus.imem_addr, 32'h0);
    chk("t6_rst_valid2", bus.instr_valid, 0);
    chk("leftover_exp", exp_q.size(), 0);
    step();
    iss_log.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_restart_req", bus.imem_req, 1);
    chk("t6_restart_addr", bus.imem_addr, 32'h0);
    step();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    consume(2, 1'b0, 32'h0);

    repeat (2) step();
    chk("final_exp_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
